// File: rtl/gate_truth_checker.sv
// Self-test sequencer for the two-input gate bank: sweeps {a,b} through all four
// vectors, checks the seven gate outputs and reports pass, error count and failing gates.
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int SWEEPS        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             and_in,
    input  logic             or_in,
    input  logic             not_in,
    input  logic             nand_in,
    input  logic             nor_in,
    input  logic             xor_in,
    input  logic             xnor_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [6:0]       fail_mask,
    output logic [1:0]       fail_vec
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SWP_W = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SWP_W-1:0] SWEEP_LAST  = SWP_W'(SWEEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SET_W-1:0]   settle_cnt;
    logic [SWP_W-1:0]   sweep;
    logic [1:0]         idx;
    logic [6:0]         expected;
    logic [6:0]         observed;
    logic [6:0]         mismatch;
    logic               any_miss;
    logic [CNT_W-1:0]   err_nxt;

    // Stimulus comes straight from the vector index register.
    assign a = idx[1];
    assign b = idx[0];

    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

    assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    assign observed = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
    assign mismatch = expected ^ observed;
    assign any_miss = |mismatch;
    assign err_nxt  = (any_miss && (err_count != '1)) ? err_count + 1'b1 : err_count;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nxt = CHECK;
            CHECK: begin
                if ((idx == 2'd3) && (sweep == SWEEP_LAST)) state_nxt = DONE;
                else state_nxt = SETTLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            sweep      <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
            fail_vec   <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        sweep      <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_mask  <= '0;
                        fail_vec   <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                CHECK: begin
                    err_count  <= err_nxt;
                    fail_mask  <= fail_mask | mismatch;
                    settle_cnt <= SETTLE_LOAD;
                    // err_count never returns to zero, so zero means no earlier miss
                    if (any_miss && (err_count == '0)) fail_vec <= {a, b};
                    if (idx != 2'd3) begin
                        idx <= idx + 2'd1;
                    end else if (sweep != SWEEP_LAST) begin
                        idx   <= '0;
                        sweep <= sweep + 1'b1;
                    end else begin
                        pass <= (err_nxt == '0);
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: three instances with faulty and
// fault-free gate-bank models, expectations queued at start, checked on done.
module tb_gate_truth_checker;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [6:0] mask;
        logic [1:0] vec;
        int         busy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic logic [6:0] gates(input logic ia, input logic ib);
        return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ~ia, ia | ib, ia & ib};
    endfunction

    // instance 0: defaults, configurable stuck-at-0 faults
    logic rst0, start0, a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [6:0] mask0, zero0, g0;
    logic [1:0] vec0;
    assign g0 = gates(a0, b0) & ~zero0;

    gate_truth_checker u0 (
        .clk(clk), .rst(rst0), .start(start0), .a(a0), .b(b0),
        .and_in(g0[0]), .or_in(g0[1]), .not_in(g0[2]), .nand_in(g0[3]),
        .nor_in(g0[4]), .xor_in(g0[5]), .xnor_in(g0[6]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_mask(mask0), .fail_vec(vec0)
    );

    // instance 1: three sweeps, nand output inverted
    logic rst1, start1, a1, b1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [6:0] mask1, g1;
    logic [1:0] vec1;
    assign g1 = gates(a1, b1) ^ 7'b0001000;

    gate_truth_checker #(.SWEEPS(3)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .and_in(g1[0]), .or_in(g1[1]), .not_in(g1[2]), .nand_in(g1[3]),
        .nor_in(g1[4]), .xor_in(g1[5]), .xnor_in(g1[6]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_mask(mask1), .fail_vec(vec1)
    );

    // instance 2: 2-bit counter, two sweeps, every output inverted
    logic rst2, start2, a2, b2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [6:0] mask2, g2;
    logic [1:0] vec2;
    assign g2 = ~gates(a2, b2);

    gate_truth_checker #(.SWEEPS(2), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2),
        .and_in(g2[0]), .or_in(g2[1]), .not_in(g2[2]), .nand_in(g2[3]),
        .nor_in(g2[4]), .xor_in(g2[5]), .xnor_in(g2[6]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_mask(mask2), .fail_vec(vec2)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic cmp_run(input string n, input exp_t e, input logic p,
                           input logic [7:0] er, input logic [6:0] m,
                           input logic [1:0] v, input int bc);
        chk({n, " pass"}, 32'(p), 32'(e.pass));
        chk({n, " err_count"}, 32'(er), 32'(e.err));
        chk({n, " fail_mask"}, 32'(m), 32'(e.mask));
        chk({n, " fail_vec"}, 32'(v), 32'(e.vec));
        chk({n, " busy cycles"}, 32'(bc), 32'(e.busy));
    endtask

    task automatic no_exp(input string n);
        nvec++;
        nerr++;
        $display("FAIL %s: done pulse with no run expected", n);
    endtask

    // monitors: per-cycle stimulus order while busy, result check on done
    int bc0 = 0, bc1 = 0, bc2 = 0;

    always @(negedge clk) begin
        if (rst0) bc0 = 0;
        else begin
            if (busy0) begin
                chk("u0 ab", 32'({a0, b0}), 32'((bc0 / 3) % 4));
                bc0++;
            end
            if (done0) begin
                chk("u0 busy in done", 32'(busy0), 0);
                if (q0.size() == 0) no_exp("u0");
                else cmp_run("u0", q0.pop_front(), pass0, err0, mask0, vec0, bc0);
                bc0 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst1) bc1 = 0;
        else begin
            if (busy1) begin
                chk("u1 ab", 32'({a1, b1}), 32'((bc1 / 3) % 4));
                bc1++;
            end
            if (done1) begin
                if (q1.size() == 0) no_exp("u1");
                else cmp_run("u1", q1.pop_front(), pass1, err1, mask1, vec1, bc1);
                bc1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst2) bc2 = 0;
        else begin
            if (busy2) bc2++;
            if (done2) begin
                if (q2.size() == 0) no_exp("u2");
                else cmp_run("u2", q2.pop_front(), pass2, {6'd0, err2}, mask2, vec2, bc2);
                bc2 = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic is_done(input int id);
        case (id)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    task automatic start_pulse(input int id);
        case (id)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        cyc(1);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int id);
        for (int i = 0; i < 200; i++) begin
            if (is_done(id)) return;
            cyc(1);
        end
        nvec++;
        nerr++;
        $display("FAIL wait_done u%0d: no done within 200 cycles", id);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        zero0 = '0;
        cyc(3);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        chk("reset ab/busy/done/pass", 32'({a0, b0, busy0, done0, pass0}), 0);
        chk("reset err/mask/vec", 32'({err0, mask0, vec0}), 0);

        // good bank, single sweep
        q0.push_back('{1'b1, 8'd0, 7'd0, 2'd0, 12});
        start_pulse(0);
        wait_done(0);
        cyc(1);
        chk("t1 done width", 32'(done0), 0);
        chk("t1 pass after done", 32'(pass0), 1);

        // xor stuck at 0
        zero0 = 7'b0100000;
        q0.push_back('{1'b0, 8'd2, 7'b0100000, 2'b01, 12});
        start_pulse(0);
        wait_done(0);
        cyc(3);
        chk("t2 pass held", 32'(pass0), 0);
        zero0 = '0;

        q1.push_back('{1'b0, 8'd12, 7'b0001000, 2'b00, 36});
        start_pulse(1);
        wait_done(1);

        q2.push_back('{1'b0, 8'd3, 7'h7F, 2'b00, 24});
        start_pulse(2);
        wait_done(2);

        // extra starts while busy and in DONE
        q0.push_back('{1'b1, 8'd0, 7'd0, 2'd0, 12});
        start_pulse(0);
        cyc(3);
        start_pulse(0);
        wait_done(0);
        start_pulse(0);
        cyc(20);
        chk("t5 no restart", 32'(busy0), 0);
        chk("t5 queue drained", 32'(q0.size()), 0);

        // start held high: back-to-back runs
        zero0 = 7'b0100000;
        q0.push_back('{1'b0, 8'd2, 7'b0100000, 2'b01, 12});
        q0.push_back('{1'b1, 8'd0, 7'd0, 2'd0, 12});
        start0 = 1'b1;
        cyc(1);
        wait_done(0);
        zero0 = '0;
        cyc(1);
        chk("t5 idle gap", 32'(busy0), 0);
        cyc(1);
        chk("t5 restart busy", 32'(busy0), 1);
        chk("t5 err cleared", 32'(err0), 0);
        start0 = 1'b0;
        wait_done(0);
        cyc(2);

        // reset during SETTLE of vector 10
        start_pulse(0);
        cyc(6);
        chk("t6 ab before rst", 32'({a0, b0}), 32'(2'b10));
        rst0 = 1'b1;
        cyc(1);
        rst0 = 1'b0;
        chk("t6 rst ab/busy/done/pass", 32'({a0, b0, busy0, done0, pass0}), 0);
        chk("t6 rst err/mask/vec", 32'({err0, mask0, vec0}), 0);
        cyc(15);
        q0.push_back('{1'b1, 8'd0, 7'd0, 2'd0, 12});
        start_pulse(0);
        wait_done(0);
        cyc(2);
        chk("all queues drained", 32'(q0.size() + q1.size() + q2.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
